xocc_dsa_alu_engine: RTL and testbench



---
 rtl/xocc_dsa_alu_engine.sv | 153 +++++++++++++++
 tb/tb_xocc_dsa_alu_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/xocc_dsa_alu_engine.sv
// xocc_dsa_alu_engine
//   DSA-side consumer of one XOCC queue. Pops a 96-bit command from the
//   first-word-fall-through command FIFO, executes a small integer op and
//   pushes a 32-bit result into the response FIFO.
//
//   Opcodes (dsa_cmd_buffer[3:0]): 0 ADD, 1 SUB, 2 MUL, 3 ACC, 4 CLR,
//   5..15 illegal (result 32'hFFFF_FFFF).
//
//   Build option: XOCC_DSA_MUL_EN
//     defined   - opcode 2 runs a 32-cycle shift-add multiplier
//     undefined - no multiplier datapath; opcode 2 is treated as illegal
//
// Ports:
//   dsa_clk, dsa_rst  clock; asynchronous active-high reset
//   empty_cmd         command FIFO empty (dsa_cmd_buffer valid when 0)
//   dsa_cmd_buffer    {operand B, operand A, opcode word}
//   rd_en_cmd         command FIFO pop strobe
//   full_rsp          response FIFO full
//   wr_en_rsp         response FIFO push strobe
//   dsa_rsp_buffer    response data (result register)
//   busy              high whenever the engine is not idle
//   cmd_cnt           number of responses pushed (wraps)
module xocc_dsa_alu_engine #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 dsa_clk,
    input  logic                 dsa_rst,
    input  logic                 empty_cmd,
    input  logic [95:0]          dsa_cmd_buffer,
    output logic                 rd_en_cmd,
    input  logic                 full_rsp,
    output logic                 wr_en_rsp,
    output logic [31:0]          dsa_rsp_buffer,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cmd_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [31:0]           a_q, a_d;
    logic [31:0]           b_q, b_d;
    logic [31:0]           acc_q, acc_d;
    logic [31:0]           result_q, result_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
`ifdef XOCC_DSA_MUL_EN
    logic [4:0]            mul_cnt_q, mul_cnt_d;
    logic [31:0]           prod_base;
`endif

    always_ff @(posedge dsa_clk or posedge dsa_rst) begin
        if (dsa_rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
`ifdef XOCC_DSA_MUL_EN
            mul_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
`ifdef XOCC_DSA_MUL_EN
            mul_cnt_q <= mul_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        rd_en_cmd = 1'b0;
        wr_en_rsp = 1'b0;
`ifdef XOCC_DSA_MUL_EN
        mul_cnt_d = mul_cnt_q;
        prod_base = '0;
`endif
        unique case (state_q)
            IDLE: begin
                // Pop is held off while reset is asserted so the FIFO is
                // never drained by a command that would be discarded.
                if (!empty_cmd && !dsa_rst) begin
                    rd_en_cmd = 1'b1;
                    op_d      = dsa_cmd_buffer[3:0];
                    a_d       = dsa_cmd_buffer[63:32];
                    b_d       = dsa_cmd_buffer[95:64];
                    state_d   = EXEC;
`ifdef XOCC_DSA_MUL_EN
                    mul_cnt_d = '0;
`endif
                end
            end
            EXEC: begin
                state_d = RESP;
                unique case (op_q)
                    4'd0: result_d = a_q + b_q;
                    4'd1: result_d = a_q - b_q;
`ifdef XOCC_DSA_MUL_EN
                    4'd2: begin
                        // Shift-add, multiplier B consumed LSB first. The
                        // product builds up in result_q; the first step
                        // starts from zero instead of the stale result.
                        prod_base = (mul_cnt_q == 5'd0) ? '0 : result_q;
                        result_d  = b_q[0] ? prod_base + a_q : prod_base;
                        a_d       = a_q << 1;
                        b_d       = b_q >> 1;
                        mul_cnt_d = mul_cnt_q + 5'd1;
                        if (mul_cnt_q != 5'd31) begin
                            state_d = EXEC;
                        end
                    end
`endif
                    4'd3: begin
                        acc_d    = acc_q + a_q;
                        result_d = acc_q + a_q;
                    end
                    4'd4: begin
                        result_d = acc_q;
                        acc_d    = '0;
                    end
                    default: result_d = 32'hFFFF_FFFF;
                endcase
            end
            RESP: begin
                if (!full_rsp) begin
                    wr_en_rsp = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dsa_rsp_buffer = result_q;
    assign busy           = (state_q != IDLE);
    assign cmd_cnt        = cnt_q;

endmodule

// File: tb/tb_xocc_dsa_alu_engine.sv
module tb_xocc_dsa_alu_engine;

    logic        dsa_clk = 1'b0;
    logic        dsa_rst;
    logic        empty_cmd;
    logic [95:0] dsa_cmd_buffer;
    logic        rd_en_cmd;
    logic        full_rsp;
    logic        wr_en_rsp;
    logic [31:0] dsa_rsp_buffer;
    logic        busy;
    logic [15:0] cmd_cnt;

    always #5 dsa_clk = ~dsa_clk;

    xocc_dsa_alu_engine #(.CNT_WIDTH(16)) dut (
        .dsa_clk        (dsa_clk),
        .dsa_rst        (dsa_rst),
        .empty_cmd      (empty_cmd),
        .dsa_cmd_buffer (dsa_cmd_buffer),
        .rd_en_cmd      (rd_en_cmd),
        .full_rsp       (full_rsp),
        .wr_en_rsp      (wr_en_rsp),
        .dsa_rsp_buffer (dsa_rsp_buffer),
        .busy           (busy),
        .cmd_cnt        (cmd_cnt)
    );

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    logic [95:0] cmd_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        pop_pending = 1'b0;
    logic [31:0] m_acc = '0;
    logic [15:0] m_cnt = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endfunction

    always @(posedge dsa_clk) cyc <= cyc + 1;

    // Monitor / scoreboard: samples on the falling edge.
    always @(negedge dsa_clk) begin : mon
        exp_t        e;
        logic [3:0]  op;
        logic [31:0] a, b, r;
        int unsigned lat;
        logic        er, ew;
        if (dsa_rst) begin
            chk("rst_rd_en", 32'(rd_en_cmd), 32'd0);
            chk("rst_wr_en", 32'(wr_en_rsp), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_cmd_cnt", 32'(cmd_cnt), 32'd0);
            chk("rst_rsp", dsa_rsp_buffer, 32'd0);
            exp_q.delete();
            m_acc = '0;
            m_cnt = '0;
        end else begin
            er = (exp_q.size() == 0) && !empty_cmd;
            ew = (exp_q.size() != 0) && (cyc >= exp_q[0].due) && !full_rsp;
            chk("rd_en_cmd", 32'(rd_en_cmd), 32'(er));
            chk("wr_en_rsp", 32'(wr_en_rsp), 32'(ew));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("cmd_cnt", 32'(cmd_cnt), 32'(m_cnt));
            if (wr_en_rsp && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_data", dsa_rsp_buffer, e.data);
                m_cnt = m_cnt + 16'd1;
            end
            if (rd_en_cmd) begin
                op  = dsa_cmd_buffer[3:0];
                a   = dsa_cmd_buffer[63:32];
                b   = dsa_cmd_buffer[95:64];
                lat = 2;
                case (op)
                    4'd0: r = a + b;
                    4'd1: r = a - b;
`ifdef XOCC_DSA_MUL_EN
                    4'd2: begin r = a * b; lat = 33; end
`endif
                    4'd3: begin m_acc = m_acc + a; r = m_acc; end
                    4'd4: begin r = m_acc; m_acc = '0; end
                    default: r = 32'hFFFF_FFFF;
                endcase
                e.data = r;
                e.due  = cyc + lat;
                exp_q.push_back(e);
                pop_pending = 1'b1;
            end
        end
    end

    task automatic refresh();
        empty_cmd      = (cmd_q.size() == 0);
        dsa_cmd_buffer = (cmd_q.size() == 0) ? '0 : cmd_q[0];
    endtask

    task automatic tick();
        logic [95:0] tmp;
        @(posedge dsa_clk);
        #1;
        if (pop_pending) begin
            tmp = cmd_q.pop_front();
            pop_pending = 1'b0;
        end
        refresh();
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        cmd_q.push_back({b, a, 28'd0, op});
        refresh();
    endtask

    task automatic drain(input int unsigned limit);
        int unsigned n = 0;
        while ((cmd_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size() + cmd_q.size());
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        dsa_rst        = 1'b1;
        full_rsp       = 1'b0;
        empty_cmd      = 1'b1;
        dsa_cmd_buffer = '0;
        repeat (3) tick();
        dsa_rst = 1'b0;
        repeat (10) tick();

        push_cmd(4'd0, 32'hFFFF_FFFF, 32'd2);
        drain(20);

        push_cmd(4'd2, 32'h0001_0003, 32'h0000_0005);
        drain(60);

        push_cmd(4'd3, 32'd10, 32'd99);
        push_cmd(4'd3, 32'd7, 32'd0);
        push_cmd(4'd4, 32'd0, 32'd0);
        drain(40);
        push_cmd(4'd3, 32'd1, 32'd0);
        drain(20);

        // Response stall with a second command queued behind it.
        push_cmd(4'd1, 32'd3, 32'd5);
        push_cmd(4'd0, 32'd1, 32'd2);
        full_rsp = 1'b1;
        repeat (20) tick();
        full_rsp = 1'b0;
        drain(20);

        // Reset in the middle of a multiply.
        push_cmd(4'd2, 32'h1234_5678, 32'h9ABC_DEF1);
        repeat (11) tick();
        dsa_rst = 1'b1;
        tick();
        dsa_rst = 1'b0;
        tick();
        push_cmd(4'd0, 32'd1, 32'd1);
        drain(20);

        // Randomized traffic with back-pressure.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
                ra  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
                push_cmd(rop, ra, rb);
            end
            full_rsp = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 6)) tick();
        end
        full_rsp = 1'b0;
        drain(5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
